// File: rtl/fpga_ccff_fabric_pkg.sv
// -----------------------------------------------------------------------------
// fpga_ccff_fabric_pkg
//   Shared constants for the fabric configuration-chain core: the default
//   fabric sizes and the layout of the per-pad control fields at the head of
//   the configuration chain.
// -----------------------------------------------------------------------------
package fpga_ccff_fabric_pkg;

  // Default fabric dimensions.
  localparam int DEFAULT_FPGA_IO_SIZE        = 24;
  localparam int DEFAULT_FPGA_BITSTREAM_SIZE = 1966;

  // Each pad owns PAD_STRIDE consecutive chain bits starting at PAD_STRIDE*i.
  localparam int PAD_STRIDE    = 3;
  localparam int PAD_DIR_OFS   = 0;  // 1 = fabric drives the pad
  localparam int PAD_SEL_OFS   = 1;  // 1 = loop back SOC_IN, 0 = constant
  localparam int PAD_CONST_OFS = 2;  // constant level when sel = 0

  // Chain index of a given field of pad i.
  function automatic int pad_bit(input int pad, input int ofs);
    return pad * PAD_STRIDE + ofs;
  endfunction

endpackage

// File: rtl/fpga_ccff_fabric_ccff.sv
// -----------------------------------------------------------------------------
// ccff_chain
//   Parameterised N-bit serial configuration shift register.
//   Ports:
//     prog_clk      : rising-edge clock
//     pReset        : asynchronous active-high clear of every chain bit
//     config_enable : 1 = shift one position per edge, 0 = hold
//     ccff_head     : serial data in, captured into cc[0]
//     cc[0:N-1]     : parallel view of the chain
//     ccff_tail     : serial data out, equal to cc[N-1]
//   N must be at least 2 (the fabric always satisfies this).
// -----------------------------------------------------------------------------
module ccff_chain #(
  parameter int N = 1966
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         config_enable,
  input  logic         ccff_head,
  output logic [0:N-1] cc,
  output logic         ccff_tail
);

  // With an ascending range the leftmost concatenation element lands in cc[0],
  // so this moves every bit one index up and inserts the head at the bottom.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cc <= '0;
    end else if (config_enable) begin
      cc <= {ccff_head, cc[0:N-2]};
    end
  end

  assign ccff_tail = cc[N-1];

endmodule

// File: rtl/fpga_ccff_fabric.sv
// -----------------------------------------------------------------------------
// fpga_ccff_fabric
//   Configuration-chain core of the embedded FPGA fabric. Holds the bitstream
//   in one serial chain and decodes the first 3*FPGA_IO_SIZE bits into the
//   SoC-facing pad controls.
//   Ports:
//     prog_clk, pReset, config_enable, ccff_head, ccff_tail : chain load path
//     IO_ISOL_N                       : active-low pad isolation
//     gfpga_pad_sofa_plus_io_SOC_IN   : pad input values
//     gfpga_pad_sofa_plus_io_SOC_OUT  : pad output values
//     gfpga_pad_sofa_plus_io_SOC_DIR  : pad direction (1 = input/high-Z)
//     reset, clk, Test_en             : reserved, not used by this core
//   FPGA_BITSTREAM_SIZE must be >= 3*FPGA_IO_SIZE.
// -----------------------------------------------------------------------------
module fpga_ccff_fabric
  import fpga_ccff_fabric_pkg::*;
#(
  parameter int FPGA_IO_SIZE        = DEFAULT_FPGA_IO_SIZE,
  parameter int FPGA_BITSTREAM_SIZE = DEFAULT_FPGA_BITSTREAM_SIZE
) (
  input  logic                    prog_clk,
  input  logic                    pReset,
  input  logic                    config_enable,
  input  logic                    ccff_head,
  output logic                    ccff_tail,
  input  logic                    IO_ISOL_N,
  input  logic [0:FPGA_IO_SIZE-1] gfpga_pad_sofa_plus_io_SOC_IN,
  output logic [0:FPGA_IO_SIZE-1] gfpga_pad_sofa_plus_io_SOC_OUT,
  output logic [0:FPGA_IO_SIZE-1] gfpga_pad_sofa_plus_io_SOC_DIR,
  input  logic                    reset,
  input  logic                    clk,
  input  logic                    Test_en
);

  logic [0:FPGA_BITSTREAM_SIZE-1] cc;
  logic                           isolated;

  ccff_chain #(
    .N (FPGA_BITSTREAM_SIZE)
  ) u_chain (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .cc            (cc),
    .ccff_tail     (ccff_tail)
  );

  // Pads are parked (input, driving 0) whenever the chain is moving, since
  // the decoded fields are meaningless mid-load, or when isolation is asked.
  assign isolated = ~IO_ISOL_N | config_enable;

  for (genvar i = 0; i < FPGA_IO_SIZE; i++) begin : g_pad
    logic pad_dir;
    logic pad_sel;
    logic pad_const;

    assign pad_dir   = cc[pad_bit(i, PAD_DIR_OFS)];
    assign pad_sel   = cc[pad_bit(i, PAD_SEL_OFS)];
    assign pad_const = cc[pad_bit(i, PAD_CONST_OFS)];

    always_comb begin
      gfpga_pad_sofa_plus_io_SOC_DIR[i] = 1'b1;
      gfpga_pad_sofa_plus_io_SOC_OUT[i] = 1'b0;
      if (!isolated) begin
        gfpga_pad_sofa_plus_io_SOC_DIR[i] = ~pad_dir;
        if (pad_dir) begin
          // Loopback reads the pad mirrored across the I/O ring.
          gfpga_pad_sofa_plus_io_SOC_OUT[i] = pad_sel
            ? gfpga_pad_sofa_plus_io_SOC_IN[FPGA_IO_SIZE-1-i]
            : pad_const;
        end
      end
    end
  end : g_pad

  // Reserved mode inputs and the opaque fabric part of the chain have no
  // function in this core.
  logic unused_sig;
  assign unused_sig = ^{reset, clk, Test_en, cc};

endmodule

// File: tb/tb_fpga_ccff_fabric.sv
// -----------------------------------------------------------------------------
// tb_fpga_ccff_fabric
//   Self-checking bench for fpga_ccff_fabric. The reference model holds the
//   chain as a queue of bits (index k = chain position k) and derives pad
//   outputs from the field layout.
// -----------------------------------------------------------------------------
module tb_fpga_ccff_fabric;
  import fpga_ccff_fabric_pkg::*;

  localparam int M = DEFAULT_FPGA_IO_SIZE;
  localparam int N = DEFAULT_FPGA_BITSTREAM_SIZE;

  // ---------------- clock / reset / DUT ----------------
  logic         prog_clk = 1'b0;
  logic         pReset;
  logic         config_enable;
  logic         ccff_head;
  logic         ccff_tail;
  logic         IO_ISOL_N;
  logic [0:M-1] soc_in;
  logic [0:M-1] soc_out;
  logic [0:M-1] soc_dir;
  logic         reset;
  logic         clk;
  logic         Test_en;

  always #5 prog_clk = ~prog_clk;

  fpga_ccff_fabric #(
    .FPGA_IO_SIZE        (M),
    .FPGA_BITSTREAM_SIZE (N)
  ) dut (
    .prog_clk                       (prog_clk),
    .pReset                         (pReset),
    .config_enable                  (config_enable),
    .ccff_head                      (ccff_head),
    .ccff_tail                      (ccff_tail),
    .IO_ISOL_N                      (IO_ISOL_N),
    .gfpga_pad_sofa_plus_io_SOC_IN  (soc_in),
    .gfpga_pad_sofa_plus_io_SOC_OUT (soc_out),
    .gfpga_pad_sofa_plus_io_SOC_DIR (soc_dir),
    .reset                          (reset),
    .clk                            (clk),
    .Test_en                        (Test_en)
  );

  // ---------------- scoreboard ----------------
  bit model_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
    for (int k = 0; k < N; k++) model_q.push_back(1'b0);
  endtask

  // Expected pads from the model chain and the current pad-side inputs.
  task automatic check_pads(input string tag);
    logic [0:M-1] exp_dir;
    logic [0:M-1] exp_out;
    #1;
    for (int i = 0; i < M; i++) begin
      if (!IO_ISOL_N || config_enable) begin
        exp_dir[i] = 1'b1;
        exp_out[i] = 1'b0;
      end else begin
        exp_dir[i] = !model_q[3*i];
        if (!model_q[3*i])          exp_out[i] = 1'b0;
        else if (model_q[3*i + 1])  exp_out[i] = soc_in[M-1-i];
        else                        exp_out[i] = model_q[3*i + 2];
      end
    end
    check({tag, "_dir"}, 32'(soc_dir), 32'(exp_dir));
    check({tag, "_out"}, 32'(soc_out), 32'(exp_out));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: inputs change on the falling edge, tail is checked just after
  // the rising edge against the model.
  task automatic shift(input logic en, input logic head);
    @(negedge prog_clk);
    config_enable = en;
    ccff_head     = head;
    @(posedge prog_clk);
    if (en && !pReset) begin
      model_q.push_front(head);
      void'(model_q.pop_back());
    end
    #1;
    check("tail", 32'(ccff_tail), 32'(model_q[N-1]));
  endtask

  task automatic do_reset();
    @(negedge prog_clk);
    pReset        = 1'b1;
    config_enable = 1'b1;
    ccff_head     = 1'($urandom);
    model_clear();
    #1;
    check("rst_tail", 32'(ccff_tail), 32'h0);
    check("rst_dir", 32'(soc_dir), 32'(M'('1)));
    check("rst_out", 32'(soc_out), 32'h0);
    for (int c = 0; c < 4; c++) shift(1'b1, 1'($urandom));
    check_pads("rst_pads");
    @(negedge prog_clk);
    pReset = 1'b0;
  endtask

  // Sends a single 1 then zeros; disables the chain for hold_len cycles
  // starting at cycle hold_at. Checks the clock count until the 1 reaches
  // the tail and that it stays there for exactly one enabled interval.
  task automatic pulse_latency(input string tag, input int hold_at, input int hold_len);
    int found = 0;
    shift(1'b1, 1'b1);
    for (int c = 2; c <= N + hold_len + 10; c++) begin
      logic en;
      en = !(c >= hold_at && c < hold_at + hold_len);
      shift(en, 1'b0);
      if (!en) check_pads({tag, "_hold"});
      if (ccff_tail === 1'b1) begin
        found = c;
        break;
      end
    end
    check({tag, "_latency"}, 32'(found), 32'(N + hold_len));
    shift(1'b1, 1'b0);
    check({tag, "_after"}, 32'(ccff_tail), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pReset        = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    IO_ISOL_N     = 1'b1;
    soc_in        = '0;
    reset         = 1'b0;
    clk           = 1'b0;
    Test_en       = 1'b0;
    model_clear();

    // Reset state with random head.
    do_reset();

    // Head-to-tail latency of a single pulse.
    pulse_latency("pulse", 0, 0);

    // Same pulse with a 100-cycle pause mid-load.
    do_reset();
    IO_ISOL_N = 1'b1;
    soc_in    = M'($urandom);
    pulse_latency("hold", 700, 100);

    // Random load with random enable, then random pad-side inputs.
    do_reset();
    for (int c = 0; c < 3 * N; c++) begin
      shift(($urandom_range(0, 3) != 0), 1'($urandom));
      if (c % 512 == 0) check_pads("load_pads");
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    for (int t = 0; t < 20; t++) begin
      soc_in    = M'($urandom);
      IO_ISOL_N = ($urandom_range(0, 3) != 0);
      check_pads("rand_pads");
    end

    // Directed pad decode: pad0 = dir1/sel0/const1, pad1 = dir1/sel1.
    do_reset();
    begin
      logic [4:0] bits;
      bits = 5'b11101;  // shifted MSB first: cc[4..0] = 1,1,1,0,1
      for (int b = 4; b >= 0; b--) shift(1'b1, bits[b]);
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    IO_ISOL_N     = 1'b1;
    soc_in        = '0;
    soc_in[22]    = 1'b1;
    #1;
    check("dec_out01", 32'(soc_out[0:1]), 32'h3);
    check("dec_dir01", 32'(soc_dir[0:1]), 32'h0);
    check("dec_out_rest", 32'(soc_out[2:M-1]), 32'h0);
    check("dec_dir_rest", 32'(soc_dir[2:M-1]), 32'((M-2)'('1)));
    check_pads("dec_pads");
    IO_ISOL_N = 1'b0;
    #1;
    check("isol_dir", 32'(soc_dir), 32'(M'('1)));
    check("isol_out", 32'(soc_out), 32'h0);
    IO_ISOL_N = 1'b1;
    #1;
    check("unisol_out0", 32'(soc_out[0]), 32'h1);

    // Reset asserted mid-load, between clock edges.
    do_reset();
    for (int c = 0; c < 1000; c++) shift(1'b1, 1'($urandom));
    #2;
    pReset = 1'b1;
    model_clear();
    #1;
    check("midrst_tail", 32'(ccff_tail), 32'h0);
    config_enable = 1'b0;
    IO_ISOL_N     = 1'b1;
    soc_in        = M'($urandom);
    #1;
    check("midrst_dir", 32'(soc_dir), 32'(M'('1)));
    check("midrst_out", 32'(soc_out), 32'h0);
    @(negedge prog_clk);
    pReset = 1'b0;
    pulse_latency("reload", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpga_ccff_fabric.md
# fpga_ccff_fabric

Configuration-chain core of the embedded FPGA fabric, exposed at chip level as `fpga_top`. It holds the fabric bitstream in one serial shift register (the configuration chain, "ccff") loaded through `ccff_head`. The register drives `ccff_tail` for chain-integrity checks. A small decoded portion of the bitstream controls the SoC-facing I/O pads.

## Interface
- `FPGA_IO_SIZE`, 24: number of SoC I/O pads.
- `FPGA_BITSTREAM_SIZE`, 1966: configuration chain length in bits. Must be ≥ 3·`FPGA_IO_SIZE`.

- One clock. Reset is asynchronous and active-high.
- `prog_clk`  in  1: the single clock. All flops are clocked on its rising edge.
- `pReset`  in  1: asynchronous, active-high reset of the whole configuration chain.
- `config_enable`  in  1: 1 = chain shifts on each `prog_clk` rising edge; 0 = chain holds.
- `ccff_head`  in  1: serial configuration data in.
- `ccff_tail`  out  1: serial configuration data out (last chain bit).
- `IO_ISOL_N`  in  1: active-low I/O isolation.
- `gfpga_pad_sofa_plus_io_SOC_IN`  in  [0:FPGA_IO_SIZE-1]: pad input values.
- `gfpga_pad_sofa_plus_io_SOC_OUT`  out  [0:FPGA_IO_SIZE-1]: pad output values.
- `gfpga_pad_sofa_plus_io_SOC_DIR`  out  [0:FPGA_IO_SIZE-1]: pad direction; 1 = input/high-Z, 0 = driving.
- `reset`, `clk`, `Test_en`  in  1 each: reserved operating-mode inputs. They are ignored, and no flop is clocked or reset by them.

## Operation
- Chain `cc[0:N-1]`, where N = `FPGA_BITSTREAM_SIZE`.
- Shift rule, on a rising edge with `config_enable`=1 and `pReset`=0:
  - `cc[0]` <= `ccff_head`.
  - `cc[k]` <= `cc[k-1]` for k ≥ 1.
- With `config_enable`=0, the chain holds its contents.
- `ccff_tail` = `cc[N-1]`, driven combinationally.
- Load ordering: if stream bits b0..b(N-1) are shifted in b0 first, then after N enabled edges `cc[k]` = b(N-1-k).
- Pad decode, for pad i (M = `FPGA_IO_SIZE`):
  - `dir_i` = `cc[3i]`: 1 = output.
  - `sel_i` = `cc[3i+1]`.
  - `const_i` = `cc[3i+2]`.
  - Chain bits ≥ 3M are opaque fabric configuration and are not decoded here.
- Pad outputs, combinational:
  - Isolated case (`IO_ISOL_N`=0 or `config_enable`=1): SOC_DIR[i]=1 and SOC_OUT[i]=0.
  - Otherwise: SOC_DIR[i] = ~`dir_i`.
  - Otherwise: SOC_OUT[i] = `dir_i` ? (`sel_i` ? SOC_IN[M-1-i] : `const_i`) : 0.

## Timing
- `pReset`=1 clears every chain bit to 0 immediately, without waiting for a clock. It overrides shifting, including reset asserted mid-load.
- Reset output values:
  - `ccff_tail`=0.
  - SOC_DIR all 1.
  - SOC_OUT all 0.
- Loading resumes from an all-zero chain on the first enabled edge after `pReset` deasserts.
- Latency: a `ccff_head` value sampled at enabled edge e appears on `ccff_tail` after edge e+N-1, i.e. N enabled edges from head to tail.
- A single-cycle 1 on `ccff_head` followed by zeros:
  - `ccff_tail` is 1 for exactly one enabled-edge interval.
  - `ccff_tail` then returns to 0.
- `config_enable` may toggle at any time. Disabled edges do not count toward latency.
- The pad path is purely combinational from the chain, `SOC_IN`, `IO_ISOL_N` and `config_enable`. Output changes appear in the same cycle as their cause.

## Structure
- Shared package: default `FPGA_IO_SIZE` and `FPGA_BITSTREAM_SIZE` values, and the per-pad field offsets (DIR=0, SEL=1, CONST=2, stride 3).
- One sub-module, `ccff_chain`:
  - A parameterised N-bit shift register.
  - Ports: `prog_clk`, `pReset`, `config_enable`, `ccff_head`, parallel `cc`, `ccff_tail`.
- Pad decode stays in the top module as a generate loop.

## Test plan
- Reset: hold `pReset`=1 with random `ccff_head` → `ccff_tail`=0, SOC_DIR=all 1, SOC_OUT=all 0.
- Pulse propagation:
  - Stimulus: release reset, `config_enable`=1, drive `ccff_head`=1 for one cycle, then 0.
  - Response: `ccff_tail` is 0 through enabled edge 1965 and becomes 1 after edge 1966.
- Hold:
  - Stimulus: insert 100 cycles with `config_enable`=0 mid-load.
  - Response: `ccff_tail` timing is shifted by exactly 100 cycles, and the chain is unchanged while disabled.
- Pad decode:
  - Stimulus: load bits so pad 0 = (dir 1, sel 0, const 1) and pad 1 = (dir 1, sel 1). Set `config_enable`=0, `IO_ISOL_N`=1, SOC_IN[22]=1.
  - Response: SOC_OUT[0]=1, SOC_OUT[1]=1, SOC_DIR[0]=SOC_DIR[1]=0, and all other pads have DIR=1, OUT=0.
- Isolation: with the same configuration, drive `IO_ISOL_N`=0 → SOC_DIR=all 1, SOC_OUT=all 0 immediately.
- Reset mid-load: assert `pReset` after 1000 shifts → chain all 0. After reload, a fresh pulse again takes exactly 1966 enabled edges to reach `ccff_tail`.
